imem_arbiter: RTL

Shares the single-port, synchronous instruction memory between the core's fetch port (read-only) and the program loader (write-only, used for boot/debug download). Arbitrates with round-robin fairness, supports a loader lock for burst downloads, and checks fetch addresses against the 256-word (1 KB) memory window. Sits between the PC/fetch stage, the loader, and the memory macro.

---
 rtl/imem_arbiter_if.sv | 82 ++++++++
 rtl/imem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter_if.sv
//------------------------------------------------------------------------------
// imem_arbiter_if
//
// Bundles the three buses that meet at the instruction-memory arbiter:
//   fetch port  : f_req, f_addr -> f_gnt, f_rvalid, f_rdata, f_err
//   loader port : ld_req, ld_addr, ld_wdata, ld_lock -> ld_gnt, ld_count
//   memory port : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//
// Modports:
//   slave  : the arbiter itself (consumes requests, drives grants and memory)
//   master : the surrounding system (fetch stage, loader and memory macro)
//
// DEPTH_LOG2 must match the arbiter instance it is connected to.
//------------------------------------------------------------------------------
interface imem_arbiter_if #(
   parameter int DEPTH_LOG2 = 8
);

   // fetch port
   logic                  f_req;
   logic [31:0]           f_addr;
   logic                  f_gnt;
   logic                  f_rvalid;
   logic [31:0]           f_rdata;
   logic                  f_err;

   // loader port
   logic                  ld_req;
   logic [31:0]           ld_addr;
   logic [31:0]           ld_wdata;
   logic                  ld_lock;
   logic                  ld_gnt;
   logic [DEPTH_LOG2:0]   ld_count;

   // memory macro port
   logic                  mem_en;
   logic                  mem_we;
   logic [DEPTH_LOG2-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;

   modport slave (
      input  f_req,
      input  f_addr,
      output f_gnt,
      output f_rvalid,
      output f_rdata,
      output f_err,
      input  ld_req,
      input  ld_addr,
      input  ld_wdata,
      input  ld_lock,
      output ld_gnt,
      output ld_count,
      output mem_en,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata
   );

   modport master (
      output f_req,
      output f_addr,
      input  f_gnt,
      input  f_rvalid,
      input  f_rdata,
      input  f_err,
      output ld_req,
      output ld_addr,
      output ld_wdata,
      output ld_lock,
      input  ld_gnt,
      input  ld_count,
      input  mem_en,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/imem_arbiter.sv
//------------------------------------------------------------------------------
// imem_arbiter
//
// Shares a single-port synchronous instruction memory between the core fetch
// port (read-only) and the program loader (write-only). Round-robin between
// the two, with a loader lock that gives the loader exclusive ownership for
// burst downloads. Addresses are checked against the 4*2^DEPTH_LOG2-byte
// window; bad fetches return NOP_WORD with f_err, bad loader writes are
// silently dropped.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   bus    : imem_arbiter_if.slave carrying fetch, loader and memory buses
//
// Parameters:
//   DEPTH_LOG2 : log2 of memory depth in 32-bit words
//   NOP_WORD   : instruction returned on an errored fetch
//------------------------------------------------------------------------------
module imem_arbiter #(
   parameter int          DEPTH_LOG2 = 8,
   parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
   input  logic           clk,
   input  logic           rst_n,
   imem_arbiter_if.slave  bus
);

   //---------------------------------------------------------------------------
   // Constants
   //---------------------------------------------------------------------------
   localparam logic [0:0] ST_SHARED = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // encoding of the last_gnt register
   localparam logic GNT_F  = 1'b0;
   localparam logic GNT_LD = 1'b1;

   // requester index into the per-port decode arrays
   localparam int IDX_F  = 0;
   localparam int IDX_LD = 1;

   localparam logic [DEPTH_LOG2:0] LD_COUNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

   //---------------------------------------------------------------------------
   // State
   //---------------------------------------------------------------------------
   logic [0:0]          state_reg;
   logic [0:0]          state_next;
   logic                last_gnt_reg;
   logic                last_gnt_next;
   logic                f_rvalid_reg;
   logic                f_rvalid_next;
   logic                f_err_reg;
   logic                f_err_next;
   logic [DEPTH_LOG2:0] ld_count_reg;
   logic [DEPTH_LOG2:0] ld_count_next;

   //---------------------------------------------------------------------------
   // Per-requester address decode
   //---------------------------------------------------------------------------
   logic [31:0]           req_addr  [2];
   logic [1:0]            addr_err;
   logic [DEPTH_LOG2-1:0] word_addr [2];

   assign req_addr[IDX_F]  = bus.f_addr;
   assign req_addr[IDX_LD] = bus.ld_addr;

   // Both ports share the same window check: word aligned and no bits set
   // above the top of the memory.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_addr_dec
         logic misaligned;
         logic out_of_range;

         assign misaligned   = |req_addr[gi][1:0];
         assign out_of_range = |req_addr[gi][31:DEPTH_LOG2+2];
         assign addr_err[gi] = misaligned | out_of_range;
         assign word_addr[gi] = req_addr[gi][DEPTH_LOG2+1:2];
      end
   endgenerate

   //---------------------------------------------------------------------------
   // Arbitration
   //---------------------------------------------------------------------------
   logic lock_hold;
   logic f_gnt_c;
   logic ld_gnt_c;
   logic f_mem_ok;
   logic ld_mem_ok;

   // The lock is only honoured while ld_lock stays high; the first cycle with
   // ld_lock low is already arbitrated as SHARED.
   assign lock_hold = (state_reg == ST_LOCKED) && bus.ld_lock;

   always_comb begin
      f_gnt_c  = 1'b0;
      ld_gnt_c = 1'b0;
      if (!rst_n) begin
         f_gnt_c  = 1'b0;
         ld_gnt_c = 1'b0;
      end else if (lock_hold) begin
         ld_gnt_c = bus.ld_req;
      end else if (bus.f_req && bus.ld_req) begin
         // conflict: the side that did not win last time wins now
         if (last_gnt_reg == GNT_LD) begin
            f_gnt_c = 1'b1;
         end else begin
            ld_gnt_c = 1'b1;
         end
      end else begin
         f_gnt_c  = bus.f_req;
         ld_gnt_c = bus.ld_req;
      end
   end

   // A granted request with a bad address still consumes its turn but never
   // reaches the memory.
   assign f_mem_ok  = f_gnt_c  && !addr_err[IDX_F];
   assign ld_mem_ok = ld_gnt_c && !addr_err[IDX_LD];

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_next = ST_SHARED;
      if (lock_hold) begin
         state_next = ST_LOCKED;
      end else if (ld_gnt_c && bus.ld_lock) begin
         state_next = ST_LOCKED;
      end
   end

   always_comb begin
      last_gnt_next = last_gnt_reg;
      if (ld_gnt_c) begin
         last_gnt_next = GNT_LD;
      end else if (f_gnt_c) begin
         last_gnt_next = GNT_F;
      end
   end

   always_comb begin
      ld_count_next = ld_count_reg;
      if (ld_mem_ok && (ld_count_reg != LD_COUNT_MAX)) begin
         ld_count_next = ld_count_reg + 1'b1;
      end
   end

   assign f_rvalid_next = f_gnt_c;
   assign f_err_next    = f_gnt_c && addr_err[IDX_F];

   //---------------------------------------------------------------------------
   // Registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= ST_SHARED;
         last_gnt_reg <= GNT_LD;
         f_rvalid_reg <= 1'b0;
         f_err_reg    <= 1'b0;
         ld_count_reg <= '0;
      end else begin
         state_reg    <= state_next;
         last_gnt_reg <= last_gnt_next;
         f_rvalid_reg <= f_rvalid_next;
         f_err_reg    <= f_err_next;
         ld_count_reg <= ld_count_next;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign bus.f_gnt    = f_gnt_c;
   assign bus.ld_gnt   = ld_gnt_c;
   assign bus.f_rvalid = f_rvalid_reg;
   assign bus.f_err    = f_err_reg;
   // memory read data arrives one cycle after the grant, aligned with f_rvalid
   assign bus.f_rdata  = f_err_reg ? NOP_WORD : bus.mem_rdata;
   assign bus.ld_count = ld_count_reg;

   assign bus.mem_en    = f_mem_ok || ld_mem_ok;
   assign bus.mem_we    = ld_mem_ok;
   assign bus.mem_addr  = ld_gnt_c ? word_addr[IDX_LD] : word_addr[IDX_F];
   assign bus.mem_wdata = ld_mem_ok ? bus.ld_wdata : 32'h0;

endmodule
